tank_sprite_fetch: RTL and testbench

//  Read-side client of a 4-bit-per-pixel sprite frame RAM (50x50 tank image, stored facing DOWN,

---
 rtl/tank_pkg.sv | 25 ++
 rtl/tank_sprite_fetch_if.sv | 21 ++
 rtl/sprite_line_buffer.sv | 31 +++
 rtl/tank_sprite_fetch.sv | 199 +++++++++++++++++++
 tb/tb_tank_sprite_fetch.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tank_pkg.sv
// Shared types and sprite geometry defaults for the tank sprite path.
// Imported by the fetch unit and by frameRAM users.
package tank_pkg;

   typedef enum logic [1:0] {
      UP,
      RIGHT,
      DOWN,
      LEFT
   } dir_t;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      READY
   } fetch_state_t;

   localparam int DEF_SPR_W  = 50;
   localparam int DEF_SPR_H  = 50;
   localparam int DEF_PIX_W  = 4;
   localparam int DEF_ADDR_W = 19;
   localparam int DEF_TRANSP = 0;

endpackage

// File: rtl/tank_sprite_fetch_if.sv
// Read port between the sprite fetch unit and a tank frameRAM.
// Data is valid one cycle after the address.
interface tank_sprite_fetch_if #(
   parameter int ADDR_W = 19,
   parameter int PIX_W  = 4
);

   logic [ADDR_W-1:0] ram_addr;
   logic [PIX_W-1:0]  ram_data;

   modport master (
      output ram_addr,
      input  ram_data
   );

   modport slave (
      input  ram_addr,
      output ram_data
   );

endinterface

// File: rtl/sprite_line_buffer.sv
// One sprite row of palette indices.
// Single write port, asynchronous read port.
module sprite_line_buffer #(
   parameter int SPR_W = 50,
   parameter int PIX_W = 4,
   parameter int AW    = $clog2(SPR_W)
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [PIX_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [PIX_W-1:0] rdata
);

   logic [PIX_W-1:0] mem [SPR_W];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < SPR_W; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (waddr < AW'(SPR_W))) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = (raddr < AW'(SPR_W)) ? mem[raddr] : '0;

endmodule

// File: rtl/tank_sprite_fetch.sv
// Prefetches one tank sprite row per scanline during hblank and
// serves the palette index for DrawX during active video.
module tank_sprite_fetch
   import tank_pkg::*;
#(
   parameter int SPR_W  = DEF_SPR_W,
   parameter int SPR_H  = DEF_SPR_H,
   parameter int PIX_W  = DEF_PIX_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int TRANSP = DEF_TRANSP
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                frame_start,
   input  logic                line_start,
   input  logic [9:0]          next_y,
   input  logic [9:0]          tank_x,
   input  logic [9:0]          tank_y,
   input  logic [1:0]          dir,
   input  logic [9:0]          DrawX,
   tank_sprite_fetch_if.master ram,
   output logic [PIX_W-1:0]    pixel_idx,
   output logic                pixel_on,
   output logic                busy
);

   localparam int CW = $clog2(SPR_W);

   fetch_state_t      state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   logic [CW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_nx;
   dir_t              fdir_q, fdir_d;
   dir_t              ldir_q, ldir_d;
   logic [9:0]        lx_q, lx_d;
   logic [9:0]        ly_q, ly_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              hit_q, hit_d;

   dir_t              e_dir;
   logic [9:0]        e_y;
   logic [10:0]       r_s;
   logic              r_in;
   logic [CW-1:0]     r_row;

   logic              we;
   logic [CW-1:0]     waddr;
   logic [10:0]       dx;
   logic              in_rng;
   logic              show;
   logic [PIX_W-1:0]  rd;

   // Stored image faces DOWN; other facings are pure address remaps.
   function automatic logic [ADDR_W-1:0] map_addr(
      input dir_t          d,
      input logic [CW-1:0] r,
      input logic [CW-1:0] c
   );
      logic [CW-1:0] sr;
      logic [CW-1:0] sc;
      sr = '0;
      sc = '0;
      unique case (d)
         DOWN: begin
            sr = r;
            sc = c;
         end
         UP: begin
            sr = CW'(SPR_H - 1) - r;
            sc = c;
         end
         LEFT: begin
            sr = c;
            sc = r;
         end
         RIGHT: begin
            sr = CW'(SPR_W - 1) - c;
            sc = r;
         end
      endcase
      return ADDR_W'(sr) * ADDR_W'(SPR_W) + ADDR_W'(sc);
   endfunction

   // A coincident frame_start supplies the position for this line.
   assign e_dir = frame_start ? dir_t'(dir) : ldir_q;
   assign e_y   = frame_start ? tank_y : ly_q;
   assign r_s   = {1'b0, next_y} - {1'b0, e_y};
   assign r_in  = !r_s[10] && (r_s < 11'(SPR_H));
   assign r_row = r_s[CW-1:0];
   assign col_nx = col_q + CW'(1);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         fdir_q  <= DOWN;
         ldir_q  <= DOWN;
         lx_q    <= '0;
         ly_q    <= '0;
         addr_q  <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         fdir_q  <= fdir_d;
         ldir_q  <= ldir_d;
         lx_q    <= lx_d;
         ly_q    <= ly_d;
         addr_q  <= addr_d;
         hit_q   <= hit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      fdir_d  = fdir_q;
      ldir_d  = ldir_q;
      lx_d    = lx_q;
      ly_d    = ly_q;
      addr_d  = addr_q;
      hit_d   = hit_q;
      if (frame_start) begin
         lx_d   = tank_x;
         ly_d   = tank_y;
         ldir_d = dir_t'(dir);
      end
      // line_start always wins, aborting any fetch in flight.
      if (line_start) begin
         hit_d = 1'b0;
         if (r_in) begin
            state_d = FETCH;
            col_d   = '0;
            row_d   = r_row;
            fdir_d  = e_dir;
            addr_d  = map_addr(e_dir, r_row, '0);
         end else begin
            state_d = IDLE;
         end
      end else begin
         unique case (state_q)
            FETCH: begin
               if (col_q == CW'(SPR_W - 1)) begin
                  state_d = DRAIN;
               end else begin
                  col_d  = col_nx;
                  addr_d = map_addr(fdir_q, row_q, col_nx);
               end
            end
            DRAIN: begin
               state_d = READY;
               hit_d   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Data returned now belongs to the column issued last cycle.
   assign we = ((state_q == FETCH) && (col_q != '0)) ||
               (state_q == DRAIN);
   assign waddr = (state_q == DRAIN) ? CW'(SPR_W - 1) :
                  col_q - CW'(1);

   sprite_line_buffer #(
      .SPR_W (SPR_W),
      .PIX_W (PIX_W),
      .AW    (CW)
   ) u_lbuf (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .we      (we),
      .waddr   (waddr),
      .wdata   (ram.ram_data),
      .raddr   (dx[CW-1:0]),
      .rdata   (rd)
   );

   assign dx     = {1'b0, DrawX} - {1'b0, lx_q};
   assign in_rng = !dx[10] && (dx < 11'(SPR_W));
   assign show   = (state_q == READY) && hit_q && in_rng;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pixel_idx <= '0;
         pixel_on  <= 1'b0;
      end else begin
         pixel_idx <= show ? rd : '0;
         pixel_on  <= show && (rd != PIX_W'(TRANSP));
      end
   end

   assign busy         = (state_q == FETCH) || (state_q == DRAIN);
   assign ram.ram_addr = addr_q;

endmodule

// File: tb/tb_tank_sprite_fetch.sv
// Scoreboard bench for tank_sprite_fetch with a mem[a]=a[3:0] RAM model.
// Stimulus queues expected addresses/pixels; a monitor pops and compares.
module tb_tank_sprite_fetch;
   import tank_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       frame_start;
   logic       line_start;
   logic [9:0] next_y;
   logic [9:0] tank_x;
   logic [9:0] tank_y;
   logic [1:0] dir;
   logic [9:0] DrawX;
   logic [3:0] pixel_idx;
   logic       pixel_on;
   logic       busy;

   tank_sprite_fetch_if bus ();

   always #5 Clk = ~Clk;

   always @(posedge Clk) bus.ram_data <= bus.ram_addr[3:0];

   tank_sprite_fetch dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .frame_start (frame_start),
      .line_start  (line_start),
      .next_y      (next_y),
      .tank_x      (tank_x),
      .tank_y      (tank_y),
      .dir         (dir),
      .DrawX       (DrawX),
      .ram         (bus),
      .pixel_idx   (pixel_idx),
      .pixel_on    (pixel_on),
      .busy        (busy)
   );

   typedef struct {
      logic       on;
      logic [3:0] idx;
   } pix_t;

   logic [31:0] aq[$];
   pix_t        pq[$];
   bit          pix_pend = 1'b0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      pix_t p;
      if (Reset_n && busy && aq.size() > 0) begin
         chk("ram_addr", 32'(bus.ram_addr), aq.pop_front());
      end
      if (pix_pend) begin
         if (pq.size() == 0) begin
            chk("pix_queue_underrun", 1, 0);
         end else begin
            p = pq.pop_front();
            chk("pixel_on", 32'(pixel_on), 32'(p.on));
            chk("pixel_idx", 32'(pixel_idx), 32'(p.idx));
         end
      end
   end

   function automatic int exp_addr(dir_t d, int r, int c);
      case (d)
         DOWN:    return r * 50 + c;
         UP:      return (49 - r) * 50 + c;
         LEFT:    return c * 50 + r;
         default: return (49 - c) * 50 + r;
      endcase
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic frame(input int x, input int y, input dir_t d);
      tank_x      = 10'(x);
      tank_y      = 10'(y);
      dir         = d;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic line(input int y);
      next_y     = 10'(y);
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   task automatic push_row(input dir_t d, input int r, input int n);
      for (int c = 0; c < n; c++) begin
         aq.push_back(32'(exp_addr(d, r, c)));
      end
   endtask

   task automatic wait_busy(input string nm, input int exp);
      int n;
      n = 0;
      while (n < 200) begin
         @(negedge Clk);
         if (!busy) break;
         n++;
      end
      chk(nm, n, exp);
      tick();
   endtask

   task automatic probe(input int x, input logic on, input int idx);
      pix_t p;
      DrawX = 10'(x);
      tick();
      p.on  = on;
      p.idx = 4'(idx);
      pq.push_back(p);
      pix_pend = 1'b1;
      tick();
      pix_pend = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      Reset_n     = 1'b0;
      frame_start = 1'b0;
      line_start  = 1'b0;
      next_y      = '0;
      tank_x      = '0;
      tank_y      = '0;
      dir         = 2'(DOWN);
      DrawX       = '0;
      #1;
      chk("rst_addr", 32'(bus.ram_addr), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_on", 32'(pixel_on), 0);
      chk("rst_idx", 32'(pixel_idx), 0);
      tick();
      tick();
      Reset_n = 1'b1;
      tick();

      // reset while fetching column 20
      frame(100, 200, DOWN);
      line(205);
      push_row(DOWN, 5, 20);
      repeat (20) tick();
      Reset_n = 1'b0;
      #1;
      chk("midrst_addr", 32'(bus.ram_addr), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_on", 32'(pixel_on), 0);
      chk("midrst_idx", 32'(pixel_idx), 0);
      tick();
      Reset_n = 1'b1;
      tick();
      probe(110, 1'b0, 0);
      probe(100, 1'b0, 0);

      // DOWN row 5
      frame(100, 200, DOWN);
      line(205);
      push_row(DOWN, 5, 50);
      wait_busy("busy_down", 51);
      probe(110, 1'b1, 4);
      probe(106, 1'b0, 0);
      probe(149, 1'b1, 11);
      probe(150, 1'b0, 0);
      probe(99, 1'b0, 0);

      // UP row 0 starts at 2450
      frame(100, 200, UP);
      line(200);
      push_row(UP, 0, 50);
      wait_busy("busy_up", 51);
      probe(100, 1'b1, 2);

      // LEFT row 3: 3,53,...,2453
      frame(100, 200, LEFT);
      line(203);
      push_row(LEFT, 3, 50);
      wait_busy("busy_left", 51);
      probe(101, 1'b1, 5);

      // RIGHT row 3: 2453 down to 3
      frame(100, 200, RIGHT);
      line(203);
      push_row(RIGHT, 3, 50);
      wait_busy("busy_right", 51);
      probe(100, 1'b1, 5);
      probe(149, 1'b1, 3);

      // bottom/right screen edge
      frame(620, 460, DOWN);
      line(479);
      push_row(DOWN, 19, 50);
      wait_busy("busy_edge", 51);
      probe(639, 1'b1, 9);
      probe(619, 1'b0, 0);

      // line above sprite: no fetch
      frame(100, 200, DOWN);
      line(199);
      @(negedge Clk);
      chk("nofetch_busy", 32'(busy), 0);
      tick();
      probe(110, 1'b0, 0);

      // abort at column 30, restart on row 6
      line(205);
      push_row(DOWN, 5, 31);
      repeat (30) tick();
      line(206);
      push_row(DOWN, 6, 50);
      wait_busy("busy_restart", 51);
      probe(100, 1'b1, 12);
      probe(104, 1'b0, 0);

      // frame_start and line_start together
      tank_x      = 10'd100;
      tank_y      = 10'd206;
      dir         = 2'(DOWN);
      next_y      = 10'd206;
      frame_start = 1'b1;
      line_start  = 1'b1;
      tick();
      frame_start = 1'b0;
      line_start  = 1'b0;
      push_row(DOWN, 0, 50);
      wait_busy("busy_coinc", 51);
      probe(105, 1'b1, 5);
      probe(116, 1'b0, 0);

      tick();
      chk("addr_queue_left", 32'(aq.size()), 0);
      chk("pix_queue_left", 32'(pq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
